dose_scheduler: RTL and testbench

//   Downstream consumer of the hh:mm:ss timekeeper. Holds a table of NUM_SLOTS programmable

---
 rtl/dose_pkg.sv | 22 ++
 rtl/dose_slot_table.sv | 41 ++++
 rtl/dose_scheduler.sv | 138 +++++++++++++
 tb/tb_dose_scheduler.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dose_pkg.sv
// Shared types and constants for the dose scheduler.
//   state_t : scheduler FSM state (IDLE, RING)
//   slot_t  : one programmed dose time {hour, minute, en}
//   LED_OFF : all-ones pattern for the active-low compartment LEDs
package dose_pkg;

    typedef enum logic {IDLE, RING} state_t;

    localparam int SLOT_W    = 3;
    localparam int HOUR_W    = 5;
    localparam int MIN_W     = 6;
    localparam int MAX_SLOTS = 8;

    localparam logic [MAX_SLOTS-1:0] LED_OFF = '1;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  minute;
        logic              en;
    } slot_t;

endpackage

// File: rtl/dose_slot_table.sv
// Programmable table of dose times, one entry per compartment.
//   clk, rst        : clock, synchronous active-high reset (clears every entry)
//   i_cfg_we        : write strobe; i_cfg_slot selects the entry
//   i_cfg_hour/min/en : value written
//   i_hour/i_minute : current time from the timekeeper
//   o_match         : per-slot combinational match (enabled and hh:mm equal)
// Indices at or above NUM_SLOTS select no entry, so such writes are dropped.
module dose_slot_table
    import dose_pkg::*;
#(
    parameter int NUM_SLOTS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_cfg_we,
    input  logic [SLOT_W-1:0]    i_cfg_slot,
    input  logic [HOUR_W-1:0]    i_cfg_hour,
    input  logic [MIN_W-1:0]     i_cfg_minute,
    input  logic                 i_cfg_en,
    input  logic [HOUR_W-1:0]    i_hour,
    input  logic [MIN_W-1:0]     i_minute,
    output logic [NUM_SLOTS-1:0] o_match
);

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        slot_t r_entry;

        always_ff @(posedge clk) begin
            if (rst)
                r_entry <= '0;
            else if (i_cfg_we && i_cfg_slot == SLOT_W'(g))
                r_entry <= '{hour: i_cfg_hour, minute: i_cfg_minute, en: i_cfg_en};
        end

        // Reads the registered entry, so a write landing on a match cycle
        // only takes effect for later matches.
        assign o_match[g] = r_entry.en && (r_entry.hour == i_hour) &&
                            (r_entry.minute == i_minute);
    end

endmodule

// File: rtl/dose_scheduler.sv
// Dose alarm scheduler fed by an hh:mm:ss timekeeper.
//   clk, rst      : clock, synchronous active-high reset
//   hour/minute/second : current time
//   key_ack       : debounced acknowledge key (level)
//   cfg_*         : slot table write port
//   alarm         : 1 Hz blink while ringing
//   slot_led_n    : active-low one-hot LED of the ringing slot
//   active_slot   : index of ringing slot, 0 when idle
//   dose_taken    : 1-cycle pulse on acknowledge while ringing
//   dose_missed   : 1-cycle pulse on ring timeout
//   missed_count  : saturating missed-dose counter
module dose_scheduler
    import dose_pkg::*;
#(
    parameter int NUM_SLOTS    = 5,
    parameter int RING_SECONDS = 60,
    parameter int MISS_CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [HOUR_W-1:0]     hour,
    input  logic [MIN_W-1:0]      minute,
    input  logic [5:0]            second,
    input  logic                  key_ack,
    input  logic                  cfg_we,
    input  logic [SLOT_W-1:0]     cfg_slot,
    input  logic [HOUR_W-1:0]     cfg_hour,
    input  logic [MIN_W-1:0]      cfg_minute,
    input  logic                  cfg_en,
    output logic                  alarm,
    output logic [NUM_SLOTS-1:0]  slot_led_n,
    output logic [SLOT_W-1:0]     active_slot,
    output logic                  dose_taken,
    output logic                  dose_missed,
    output logic [MISS_CNT_W-1:0] missed_count
);

    localparam int RC_W = $clog2(RING_SECONDS + 1);

    state_t               r_state;
    logic [5:0]           r_prev_second;
    logic                 r_key_ack_q;
    logic [NUM_SLOTS-1:0] r_pending;
    logic [RC_W-1:0]      r_ring_cnt;

    logic [NUM_SLOTS-1:0] w_match;
    logic [NUM_SLOTS-1:0] w_set;
    logic [NUM_SLOTS-1:0] w_pick_oh;
    logic [SLOT_W-1:0]    w_pick_idx;
    logic                 w_sec_edge;
    logic                 w_ack_edge;

    dose_slot_table #(.NUM_SLOTS(NUM_SLOTS)) u_table (
        .clk          (clk),
        .rst          (rst),
        .i_cfg_we     (cfg_we),
        .i_cfg_slot   (cfg_slot),
        .i_cfg_hour   (cfg_hour),
        .i_cfg_minute (cfg_minute),
        .i_cfg_en     (cfg_en),
        .i_hour       (hour),
        .i_minute     (minute),
        .o_match      (w_match)
    );

    assign w_sec_edge = (second != r_prev_second);
    assign w_ack_edge = key_ack & ~r_key_ack_q;
    assign w_set      = (w_sec_edge && second == '0) ? w_match : '0;

    // Lowest set pending bit, both one-hot and as an index.
    assign w_pick_oh = r_pending & (~r_pending + NUM_SLOTS'(1));

    always_comb begin
        w_pick_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--)
            if (r_pending[i]) w_pick_idx = SLOT_W'(i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_prev_second <= '0;
            r_key_ack_q   <= 1'b0;
            r_pending     <= '0;
            r_ring_cnt    <= '0;
            alarm         <= 1'b0;
            slot_led_n    <= LED_OFF[NUM_SLOTS-1:0];
            active_slot   <= '0;
            dose_taken    <= 1'b0;
            dose_missed   <= 1'b0;
            missed_count  <= '0;
        end else begin
            r_prev_second <= second;
            r_key_ack_q   <= key_ack;
            dose_taken    <= 1'b0;
            dose_missed   <= 1'b0;
            r_pending     <= r_pending | w_set;

            case (r_state)
                IDLE: begin
                    if (|r_pending) begin
                        r_state     <= RING;
                        r_pending   <= (r_pending & ~w_pick_oh) | w_set;
                        r_ring_cnt  <= '0;
                        alarm       <= 1'b1;
                        slot_led_n  <= ~w_pick_oh;
                        active_slot <= w_pick_idx;
                    end
                end
                RING: begin
                    // Ack is tested first so it beats a simultaneous timeout.
                    if (w_ack_edge) begin
                        dose_taken  <= 1'b1;
                        r_state     <= IDLE;
                        alarm       <= 1'b0;
                        slot_led_n  <= LED_OFF[NUM_SLOTS-1:0];
                        active_slot <= '0;
                    end else if (w_sec_edge) begin
                        if (r_ring_cnt == RC_W'(RING_SECONDS - 1)) begin
                            dose_missed <= 1'b1;
                            if (missed_count != '1)
                                missed_count <= missed_count + MISS_CNT_W'(1);
                            r_state     <= IDLE;
                            alarm       <= 1'b0;
                            slot_led_n  <= LED_OFF[NUM_SLOTS-1:0];
                            active_slot <= '0;
                        end else begin
                            r_ring_cnt <= r_ring_cnt + RC_W'(1);
                            alarm      <= ~alarm;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dose_scheduler.sv
module tb_dose_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] hour = '0;
    logic [5:0] minute = '0;
    logic [5:0] second = '0;
    logic       key_ack = 1'b0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_slot = '0;
    logic [4:0] cfg_hour = '0;
    logic [5:0] cfg_minute = '0;
    logic       cfg_en = 1'b0;
    logic       alarm;
    logic [4:0] slot_led_n;
    logic [2:0] active_slot;
    logic       dose_taken;
    logic       dose_missed;
    logic [7:0] missed_count;

    always #10 clk = ~clk;

    dose_scheduler #(.NUM_SLOTS(5), .RING_SECONDS(60), .MISS_CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .hour         (hour),
        .minute       (minute),
        .second       (second),
        .key_ack      (key_ack),
        .cfg_we       (cfg_we),
        .cfg_slot     (cfg_slot),
        .cfg_hour     (cfg_hour),
        .cfg_minute   (cfg_minute),
        .cfg_en       (cfg_en),
        .alarm        (alarm),
        .slot_led_n   (slot_led_n),
        .active_slot  (active_slot),
        .dose_taken   (dose_taken),
        .dose_missed  (dose_missed),
        .missed_count (missed_count)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [7:0]  exp_cnt = '0;
    logic [18:0] exp_q[$];
    logic [18:0] e;
    wire  [18:0] obs = {alarm, slot_led_n, active_slot, dose_taken, dose_missed, missed_count};

    function automatic logic [18:0] mk(logic a, logic [4:0] led, logic [2:0] act,
                                       logic tk, logic ms, logic [7:0] cnt);
        return {a, led, act, tk, ms, cnt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        hour = h; minute = m; second = s;
        tick();
    endtask

    task automatic cfg(input logic [2:0] sl, input logic [4:0] h, input logic [5:0] m, input logic en);
        cfg_we = 1'b1; cfg_slot = sl; cfg_hour = h; cfg_minute = m; cfg_en = en;
        tick();
        cfg_we = 1'b0;
    endtask

    // Seconds alternate 1/2 so every change is a second edge but never a :00 match.
    task automatic ring_edges(input int n);
        for (int i = 0; i < n; i++) begin
            second = (second == 6'd1) ? 6'd2 : 6'd1;
            tick();
        end
    endtask

    // Fires slot 3 (09:15) and leaves it ringing.
    task automatic start_ring3();
        drive_time(5'd9, 6'd14, 6'd59);
        drive_time(5'd9, 6'd15, 6'd0);
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        exp_q.push_back(mk(1'b0, 5'b11111, 3'd0, 1'b0, 1'b0, 8'd0));
        tick();
        e = exp_q.pop_front(); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL reset_state got %h exp %h", obs, e); end
        rst = 1'b0;
    endtask

    task automatic test_match_ack();
        cfg(3'd2, 5'd7, 6'd30, 1'b1);
        drive_time(5'd7, 6'd29, 6'd59);
        drive_time(5'd7, 6'd30, 6'd0);
        exp_q.push_back(mk(1'b1, 5'b11011, 3'd2, 1'b0, 1'b0, exp_cnt));
        tick();
        e = exp_q.pop_front(); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL match_ring got %h exp %h", obs, e); end

        exp_q.push_back(mk(1'b0, 5'b11011, 3'd2, 1'b0, 1'b0, exp_cnt));
        ring_edges(1);
        e = exp_q.pop_front(); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL blink_low got %h exp %h", obs, e); end

        exp_q.push_back(mk(1'b1, 5'b11011, 3'd2, 1'b0, 1'b0, exp_cnt));
        ring_edges(1);
        e = exp_q.pop_front(); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL blink_high got %h exp %h", obs, e); end

        ring_edges(1);
        key_ack = 1'b1;
        exp_q.push_back(mk(1'b0, 5'b11111, 3'd0, 1'b1, 1'b0, exp_cnt));
        tick();
        e = exp_q.pop_front(); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL ack_taken got %h exp %h", obs, e); end

        exp_q.push_back(mk(1'b0, 5'b11111, 3'd0, 1'b0, 1'b0, exp_cnt));
        tick();
        e = exp_q.pop_front(); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL taken_one_cycle got %h exp %h", obs, e); end
        key_ack = 1'b0;
        tick();
    endtask

    task automatic test_priority();
        cfg(3'd1, 5'd8, 6'd0, 1'b1);
        cfg(3'd4, 5'd8, 6'd0, 1'b1);
        cfg(3'd0, 5'd8, 6'd0, 1'b0);
        drive_time(5'd7, 6'd59, 6'd59);
        drive_time(5'd8, 6'd0, 6'd0);
        exp_q.push_back(mk(1'b1, 5'b11101, 3'd1, 1'b0, 1'b0, exp_cnt));
        tick();
        e = exp_q.pop_front(); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL prio_slot1 got %h exp %h", obs, e); end

        key_ack = 1'b1;
        exp_q.push_back(mk(1'b0, 5'b11111, 3'd0, 1'b1, 1'b0, exp_cnt));
        tick();
        e = exp_q.pop_front(); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL prio_ack1 got %h exp %h", obs, e); end

        key_ack = 1'b0;
        exp_q.push_back(mk(1'b1, 5'b01111, 3'd4, 1'b0, 1'b0, exp_cnt));
        tick();
        e = exp_q.pop_front(); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL prio_slot4 got %h exp %h", obs, e); end

        key_ack = 1'b1;
        exp_q.push_back(mk(1'b0, 5'b11111, 3'd0, 1'b1, 1'b0, exp_cnt));
        tick();
        e = exp_q.pop_front(); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL prio_ack4 got %h exp %h", obs, e); end

        key_ack = 1'b0;
        exp_q.push_back(mk(1'b0, 5'b11111, 3'd0, 1'b0, 1'b0, exp_cnt));
        tick();
        e = exp_q.pop_front(); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL disabled_slot0_silent got %h exp %h", obs, e); end
    endtask

    task automatic test_ack_timeout();
        cfg(3'd3, 5'd9, 6'd15, 1'b1);
        start_ring3();
        exp_q.push_back(mk(1'b0, 5'b10111, 3'd3, 1'b0, 1'b0, exp_cnt));
        ring_edges(59);
        e = exp_q.pop_front(); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL pre_timeout got %h exp %h", obs, e); end

        key_ack = 1'b1;
        exp_q.push_back(mk(1'b0, 5'b11111, 3'd0, 1'b1, 1'b0, exp_cnt));
        ring_edges(1);
        e = exp_q.pop_front(); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL ack_beats_timeout got %h exp %h", obs, e); end
        key_ack = 1'b0;
        tick();
    endtask

    task automatic test_miss();
        start_ring3();
        ring_edges(59);
        exp_cnt = exp_cnt + 8'd1;
        exp_q.push_back(mk(1'b0, 5'b11111, 3'd0, 1'b0, 1'b1, exp_cnt));
        ring_edges(1);
        e = exp_q.pop_front(); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL missed_first got %h exp %h", obs, e); end

        exp_q.push_back(mk(1'b0, 5'b11111, 3'd0, 1'b0, 1'b0, exp_cnt));
        tick();
        e = exp_q.pop_front(); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL missed_one_cycle got %h exp %h", obs, e); end
    endtask

    task automatic test_key_held();
        key_ack = 1'b1;
        start_ring3();
        exp_q.push_back(mk(1'b0, 5'b10111, 3'd3, 1'b0, 1'b0, exp_cnt));
        ring_edges(1);
        e = exp_q.pop_front(); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL held_key_no_ack got %h exp %h", obs, e); end

        key_ack = 1'b0;
        exp_q.push_back(mk(1'b0, 5'b10111, 3'd3, 1'b0, 1'b0, exp_cnt));
        tick();
        e = exp_q.pop_front(); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL release_no_ack got %h exp %h", obs, e); end

        key_ack = 1'b1;
        exp_q.push_back(mk(1'b0, 5'b11111, 3'd0, 1'b1, 1'b0, exp_cnt));
        tick();
        e = exp_q.pop_front(); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL repress_ack got %h exp %h", obs, e); end
        key_ack = 1'b0;
        tick();
    endtask

    task automatic test_saturate();
        // exp_cnt is 1 here; 254 more misses bring it to 255.
        for (int k = 0; k < 254; k++) begin
            start_ring3();
            ring_edges(60);
            tick();
            if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        end
        exp_q.push_back(mk(1'b0, 5'b11111, 3'd0, 1'b0, 1'b0, exp_cnt));
        tick();
        e = exp_q.pop_front(); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL count_at_255 got %h exp %h", obs, e); end

        start_ring3();
        ring_edges(59);
        exp_q.push_back(mk(1'b0, 5'b11111, 3'd0, 1'b0, 1'b1, 8'hFF));
        ring_edges(1);
        e = exp_q.pop_front(); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL count_saturates got %h exp %h", obs, e); end
        tick();
    endtask

    task automatic test_reset_ring();
        start_ring3();
        ring_edges(2);
        rst = 1'b1;
        exp_cnt = '0;
        exp_q.push_back(mk(1'b0, 5'b11111, 3'd0, 1'b0, 1'b0, 8'd0));
        tick();
        e = exp_q.pop_front(); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL reset_mid_ring got %h exp %h", obs, e); end
        rst = 1'b0;

        cfg(3'd6, 5'd10, 6'd0, 1'b1);
        drive_time(5'd10, 6'd0, 6'd59);
        drive_time(5'd10, 6'd0, 6'd0);
        tick();
        exp_q.push_back(mk(1'b0, 5'b11111, 3'd0, 1'b0, 1'b0, 8'd0));
        tick();
        e = exp_q.pop_front(); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL cfg_slot6_ignored got %h exp %h", obs, e); end

        // Write and match on the same edge: the old (disabled) entry is used.
        drive_time(5'd10, 6'd0, 6'd59);
        hour = 5'd10; minute = 6'd1; second = 6'd0;
        cfg(3'd0, 5'd10, 6'd1, 1'b1);
        tick();
        exp_q.push_back(mk(1'b0, 5'b11111, 3'd0, 1'b0, 1'b0, 8'd0));
        tick();
        e = exp_q.pop_front(); vectors++;
        if (obs !== e) begin miscompares++; $display("FAIL write_match_same_cycle got %h exp %h", obs, e); end
    endtask

    initial begin
        #4ms;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        test_reset();
        test_match_ack();
        test_priority();
        test_ack_timeout();
        test_miss();
        test_key_held();
        test_saturate();
        test_reset_ring();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
